bram_port_client: RTL and testbench
===================================

Name: bram_port_client

Overview:
- Initiator side of one port of the dual-port byte-enable block RAM.
- Accepts read/write requests on a valid/ready interface and drives the RAM port EN/WE/ADDR/DI.
- Tracks the fixed RAM read latency (1 cycle, or 2 when pipelined) and returns read data, in order, through a small response FIFO with valid/ready backpressure.
- Instanced once per RAM port by cores that share the instruction/data memory.

Parameters:
- ADDR_WIDTH, 12: RAM word address width.
- DATA_WIDTH, 32: RAM word width.
- WE_WIDTH, 4: number of byte-enable lanes; DATA_WIDTH = WE_WIDTH*CHUNK.
- PIPELINED, 0: must match the RAM instance; read latency L = PIPELINED ? 2 : 1.
- RESP_DEPTH, 4: response FIFO depth; legal range is L+1 to 16.

Ports:
- CLK  in  1  clock; RAM port clock is the same net.
- RST_N  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_write  in  1  1 = write, 0 = read.
- req_byteen  in  WE_WIDTH  byte lanes to write; ignored for reads.
- req_addr  in  ADDR_WIDTH  word address.
- req_data  in  DATA_WIDTH  write data.
- resp_valid  out  1  read data available.
- resp_ready  in  1  consumer takes resp_data when resp_valid & resp_ready.
- resp_data  out  DATA_WIDTH  read data, in request order.
- bram_en  out  1  RAM port enable.
- bram_we  out  WE_WIDTH  RAM port byte write enables.
- bram_addr  out  ADDR_WIDTH  RAM port address.
- bram_di  out  DATA_WIDTH  RAM port write data.
- bram_do  in  DATA_WIDTH  RAM port read data.

Behaviour:
- **Clock and reset:** one clock, CLK. Reset is asynchronous and active-low on RST_N.
- **Reset values:** req_ready=0 while RST_N=0. resp_valid=0, FIFO empty, in-flight tracker cleared, outstanding=0.
- **Outputs during reset:** bram_en=0 and bram_we=0 combinationally while RST_N=0.
- **Accept:** acc = req_valid & req_ready. The RAM is driven in the same cycle:
  - bram_en = acc & (~req_write | |req_byteen)
  - bram_we = (acc & req_write) ? req_byteen : 0
  - bram_addr = req_addr; bram_di = req_data
- **Write with req_byteen=0:** accepted, but issues no RAM access and produces no response. This is required because the RAM treats WE=0 as a read.
- **Write responses:** writes never produce a response. The RAM's write-first DO value is ignored.
- **In-flight tracker:** L-stage shift register of read tags. Stage 0 is set on an accepted read. Read data is captured from bram_do into the FIFO in the cycle when stage L-1 is set, i.e. on the Lth rising edge after the accept edge.
- **Credit rule:** outstanding = fifo_count + inflight_count, both registered. req_ready = RST_N & (outstanding < RESP_DEPTH). A same-cycle pop is not credited; this is conservative and keeps ready off any combinational path from resp_ready.
  - req_ready is independent of req_write.
  - The FIFO can never overflow. Overflow is an assertion failure.
- **Back-to-back reads:** one request per cycle at full throughput while credit remains.
  - Example: RESP_DEPTH=4, L=1, resp_ready=1 → steady state of 1 req/cycle.
- **Simultaneous push and pop on a full FIFO:** both occur; count is unchanged.
- **Simultaneous push and pop on an empty FIFO:** no bypass. Data appears on resp_valid the following cycle.
- **FIFO output:** resp_data is valid only while resp_valid=1. resp_data and resp_valid are stable while resp_valid & ~resp_ready.
- **Ordering:** RAM accesses occur in accept order. A read issued the cycle after a write to the same address returns the new data.
- **Reset mid-operation:** in-flight reads and queued responses are discarded. Data returned by the RAM after RST_N rises is not captured.
- **Width rules:** inflight_count is clog2(L+1) bits. fifo_count and outstanding are clog2(RESP_DEPTH+1) bits.

Decomposition:
- Package bram_client_pkg:
  - read-latency function lat(PIPELINED)
  - request struct {write, byteen, addr, data}
  - localparam for the counter width function
- Sub-module bram_resp_fifo: synchronous FIFO, parameters DEPTH and WIDTH, async active-low reset, push/pop/count/full/empty. No bypass.

Test Plan:
- Reset, then PIPELINED=0: write addr 0x010 data 0xDEADBEEF byteen 4'hF, then read 0x010 → bram_en/bram_we=4'hF in the write cycle; resp_data=0xDEADBEEF one cycle after the read-accept edge.
- Partial write: byteen 4'b0010 data 0x0000AB00 onto 0x11223344 → readback 0x1122AB44. Write with byteen=0 → bram_en stays 0 and the word is unchanged.
- PIPELINED=1, RESP_DEPTH=4, resp_ready=0: issue 6 reads → exactly 4 accepted, then req_ready=0. Raise resp_ready → 4 responses in address order, and req_ready returns.
- Streaming: 16 back-to-back reads with resp_ready=1 → 16 accepts in 16 cycles, data in order, no bubbles after first latency.
- Random resp_ready (50%) over 1000 mixed requests → scoreboard match, FIFO never overflows, resp_data stable while stalled.
- Assert RST_N=0 with 2 reads in flight and 3 queued → resp_valid=0 immediately and req_ready=0. After release, no stale response appears and the next read returns correct data.

Source files
------------

// File: rtl/bram_client_pkg.sv
// bram_client_pkg: shared latency/width helpers and request record for the BRAM port client
package bram_client_pkg;
   localparam int DEF_ADDR_WIDTH = 12;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_WE_WIDTH   = 4;
   typedef struct packed {
      logic                      write;
      logic [DEF_WE_WIDTH-1:0]   byteen;
      logic [DEF_ADDR_WIDTH-1:0] addr;
      logic [DEF_DATA_WIDTH-1:0] data;
   } bram_req_t;
   function automatic int lat(input int pipelined);
      return (pipelined != 0) ? 2 : 1;
   endfunction
   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction
endpackage

// File: rtl/bram_resp_fifo.sv
// bram_resp_fifo: in-order read-data buffer; a pushed word is visible on dout one cycle later
module bram_resp_fifo
   import bram_client_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32,
   localparam int CW = cnt_width(DEPTH),
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic             do_push, do_pop;
   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];
   // pointers wrap at DEPTH so non-power-of-two depths work; count tracks occupancy
   always_ff @(posedge CLK or negedge RST_N)
      if (!RST_N) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   // storage is written only on an accepted push and never reset
   always_ff @(posedge CLK)
      if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/bram_port_client.sv
// bram_port_client: valid/ready initiator for one BRAM port with in-order read responses
module bram_port_client
   import bram_client_pkg::*;
#(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32,
   parameter int WE_WIDTH   = 4,
   parameter int PIPELINED  = 0,
   parameter int RESP_DEPTH = 4
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [WE_WIDTH-1:0]   req_byteen,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_data,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_WIDTH-1:0] resp_data,
   output logic                  bram_en,
   output logic [WE_WIDTH-1:0]   bram_we,
   output logic [ADDR_WIDTH-1:0] bram_addr,
   output logic [DATA_WIDTH-1:0] bram_di,
   input  logic [DATA_WIDTH-1:0] bram_do
);
   localparam int L  = lat(PIPELINED);
   localparam int IW = cnt_width(L);
   localparam int CW = cnt_width(RESP_DEPTH);
   logic          acc, rd_acc, capture, fifo_full, fifo_empty;
   logic [L-1:0]  infl;
   logic [IW-1:0] infl_cnt;
   logic [CW-1:0] fifo_cnt, outstanding;
   assign outstanding = fifo_cnt + CW'(infl_cnt);
   assign req_ready   = RST_N & (outstanding < CW'(RESP_DEPTH));
   assign acc         = req_valid & req_ready;
   assign rd_acc      = acc & ~req_write;
   assign bram_en     = acc & (~req_write | (|req_byteen));
   assign bram_we     = (acc & req_write) ? req_byteen : '0;
   assign bram_addr   = req_addr;
   assign bram_di     = req_data;
   assign capture     = infl[L-1];
   assign resp_valid  = ~fifo_empty;
   // read tags walk toward the capture stage in step with the RAM's fixed latency
   always_ff @(posedge CLK or negedge RST_N)
      if (!RST_N) begin
         infl     <= '0;
         infl_cnt <= '0;
      end else begin
         infl     <= L'({infl, rd_acc});
         infl_cnt <= infl_cnt + IW'(rd_acc) - IW'(capture);
      end
   // credit accounting must make a capture into a full, non-draining FIFO impossible
   always_ff @(posedge CLK)
      if (RST_N) assert (!(capture && fifo_full && !resp_ready));
   bram_resp_fifo #(.DEPTH(RESP_DEPTH), .WIDTH(DATA_WIDTH)) u_fifo (
      .CLK   (CLK),
      .RST_N (RST_N),
      .push  (capture),
      .din   (bram_do),
      .pop   (resp_ready),
      .dout  (resp_data),
      .count (fifo_cnt),
      .full  (fifo_full),
      .empty (fifo_empty)
   );
endmodule

// File: tb/tb_bram_port_client.sv
// tb_bram_port_client: scoreboard bench for the BRAM port client against a byte-enable RAM model
module tb_bram_port_client;
   import bram_client_pkg::*;
   localparam int N = 3;
   function automatic int pl(input int g);
      return (g == 0) ? 0 : 1;
   endfunction
   function automatic int dp(input int g);
      return (g == 2) ? 8 : 4;
   endfunction
   logic        clk = 0, rst_n = 0;
   logic        req_valid [N], req_ready [N], req_write [N], resp_valid [N], resp_ready [N], bram_en [N];
   logic [3:0]  req_byteen [N], bram_we [N];
   logic [11:0] req_addr [N], bram_addr [N];
   logic [31:0] req_data [N], resp_data [N], bram_di [N], bram_do [N];
   logic [31:0] ref_m [N][4096];
   logic [31:0] exp_q [$];
   logic [31:0] last_resp = 0;
   logic        acc_en = 0;
   logic [3:0]  acc_we = 0;
   int          checks = 0, failures = 0, cyc = 0, cur = 0, n_resp = 0, last_pop = 0, acc_cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < N; g++) begin : g_dut
      logic [31:0] mem [4096];
      logic [31:0] w, d1, d2;
      bram_port_client #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .WE_WIDTH(4), .PIPELINED(pl(g)), .RESP_DEPTH(dp(g))) u_dut (
         .CLK        (clk),
         .RST_N      (rst_n),
         .req_valid  (req_valid[g]),
         .req_ready  (req_ready[g]),
         .req_write  (req_write[g]),
         .req_byteen (req_byteen[g]),
         .req_addr   (req_addr[g]),
         .req_data   (req_data[g]),
         .resp_valid (resp_valid[g]),
         .resp_ready (resp_ready[g]),
         .resp_data  (resp_data[g]),
         .bram_en    (bram_en[g]),
         .bram_we    (bram_we[g]),
         .bram_addr  (bram_addr[g]),
         .bram_di    (bram_di[g]),
         .bram_do    (bram_do[g])
      );
      always_comb begin
         w = mem[bram_addr[g]];
         for (int i = 0; i < 4; i++) if (bram_we[g][i]) w[8*i +: 8] = bram_di[g][8*i +: 8];
      end
      always_ff @(posedge clk) begin
         if (bram_en[g]) begin
            mem[bram_addr[g]] <= w;
            d1 <= w;
         end
         d2 <= d1;
      end
      assign bram_do[g] = (pl(g) != 0) ? d2 : d1;
   end

   initial begin : monitor
      logic        p_stall, acc, e_en, e_rdy;
      logic [3:0]  e_we;
      logic [31:0] p_data, e;
      p_stall = 0;
      p_data  = 0;
      forever begin
         @(negedge clk);
         acc   = req_valid[cur] & req_ready[cur];
         e_rdy = rst_n && (exp_q.size() < dp(cur));
         checks++;
         if (req_ready[cur] !== e_rdy) begin
            failures++;
            $display("FAIL req_ready inst=%0d cyc=%0d got=%b want=%b", cur, cyc, req_ready[cur], e_rdy);
         end
         e_en = acc & (~req_write[cur] | (|req_byteen[cur]));
         e_we = (acc & req_write[cur]) ? req_byteen[cur] : 4'h0;
         checks++;
         if (bram_en[cur] !== e_en || bram_we[cur] !== e_we) begin
            failures++;
            $display("FAIL bram_ctl inst=%0d cyc=%0d got en=%b we=%h want en=%b we=%h", cur, cyc, bram_en[cur], bram_we[cur], e_en, e_we);
         end
         if (e_en) begin
            checks++;
            if (bram_addr[cur] !== req_addr[cur] || bram_di[cur] !== req_data[cur]) begin
               failures++;
               $display("FAIL bram_bus inst=%0d got addr=%h di=%h want addr=%h di=%h", cur, bram_addr[cur], bram_di[cur], req_addr[cur], req_data[cur]);
            end
         end
         if (acc && req_write[cur]) begin
            for (int i = 0; i < 4; i++)
               if (req_byteen[cur][i]) ref_m[cur][req_addr[cur]][8*i +: 8] = req_data[cur][8*i +: 8];
         end else if (acc) exp_q.push_back(ref_m[cur][req_addr[cur]]);
         if (rst_n && p_stall) begin
            checks++;
            if (resp_valid[cur] !== 1'b1 || resp_data[cur] !== p_data) begin
               failures++;
               $display("FAIL stall_hold inst=%0d got v=%b d=%h want v=1 d=%h", cur, resp_valid[cur], resp_data[cur], p_data);
            end
         end
         if (rst_n && resp_valid[cur] && resp_ready[cur]) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL resp_unexpected inst=%0d cyc=%0d got=%h want=none", cur, cyc, resp_data[cur]);
            end else begin
               e = exp_q.pop_front();
               if (resp_data[cur] !== e) begin
                  failures++;
                  $display("FAIL resp_data inst=%0d cyc=%0d got=%h want=%h", cur, cyc, resp_data[cur], e);
               end
            end
            last_resp = resp_data[cur];
            last_pop  = cyc;
            n_resp++;
         end
         p_stall = rst_n && resp_valid[cur] && !resp_ready[cur];
         p_data  = resp_data[cur];
         if (!rst_n) exp_q.delete();
      end
   end

   task automatic issue(input int k, input logic wr, input logic [3:0] be, input logic [11:0] a, input logic [31:0] d);
      int t;
      req_valid[k]  = 1;
      req_write[k]  = wr;
      req_byteen[k] = be;
      req_addr[k]   = a;
      req_data[k]   = d;
      t = 0;
      forever begin
         @(negedge clk);
         if (req_ready[k]) break;
         t++;
         if (t > 200) begin
            checks++;
            failures++;
            $display("FAIL issue_timeout inst=%0d got=stuck want=accept addr=%h", k, a);
            break;
         end
      end
      acc_cyc = cyc;
      acc_en  = bram_en[k];
      acc_we  = bram_we[k];
      @(posedge clk);
      #1 req_valid[k] = 0;
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 300) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain_timeout got=%0d want=0 pending", exp_q.size());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 0;
      for (int k = 0; k < N; k++) begin
         req_valid[k]  = 1;
         req_write[k]  = 1;
         req_byteen[k] = 4'hF;
      end
      repeat (3) @(negedge clk);
      for (int k = 0; k < N; k++) begin
         checks++;
         if (req_ready[k] !== 1'b0 || resp_valid[k] !== 1'b0 || bram_en[k] !== 1'b0 || bram_we[k] !== 4'h0) begin
            failures++;
            $display("FAIL reset_outputs inst=%0d got rdy=%b v=%b en=%b we=%h want 0", k, req_ready[k], resp_valid[k], bram_en[k], bram_we[k]);
         end
         req_valid[k]  = 0;
         req_write[k]  = 0;
         req_byteen[k] = 0;
      end
      @(posedge clk);
      #1 rst_n = 1;
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
         checks++;
         if (req_ready[k] !== 1'b1 || resp_valid[k] !== 1'b0) begin
            failures++;
            $display("FAIL post_reset inst=%0d got rdy=%b v=%b want rdy=1 v=0", k, req_ready[k], resp_valid[k]);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_basic();
      int c;
      cur = 0;
      issue(0, 1'b1, 4'hF, 12'h010, 32'hDEADBEEF);
      checks++;
      if (acc_en !== 1'b1 || acc_we !== 4'hF) begin
         failures++;
         $display("FAIL write_drive got en=%b we=%h want en=1 we=f", acc_en, acc_we);
      end
      issue(0, 1'b0, 4'h0, 12'h010, 32'h0);
      c = acc_cyc;
      wait_drain();
      checks++;
      if (last_resp !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL basic_read got=%h want=deadbeef", last_resp);
      end
      checks++;
      if (last_pop !== c + 2) begin
         failures++;
         $display("FAIL read_latency got=%0d want=%0d", last_pop - c, 2);
      end
   endtask

   task automatic test_partial();
      int n0;
      cur = 0;
      issue(0, 1'b1, 4'hF, 12'h020, 32'h11223344);
      issue(0, 1'b1, 4'b0010, 12'h020, 32'h0000AB00);
      issue(0, 1'b0, 4'h0, 12'h020, 32'h0);
      wait_drain();
      checks++;
      if (last_resp !== 32'h1122AB44) begin
         failures++;
         $display("FAIL partial_write got=%h want=1122ab44", last_resp);
      end
      n0 = n_resp;
      issue(0, 1'b1, 4'h0, 12'h020, 32'hFFFFFFFF);
      checks++;
      if (acc_en !== 1'b0 || acc_we !== 4'h0) begin
         failures++;
         $display("FAIL zero_byteen_en got en=%b we=%h want en=0 we=0", acc_en, acc_we);
      end
      issue(0, 1'b0, 4'h0, 12'h020, 32'h0);
      wait_drain();
      checks++;
      if (last_resp !== 32'h1122AB44 || n_resp !== n0 + 1) begin
         failures++;
         $display("FAIL zero_byteen_word got=%h resps=%0d want=1122ab44 resps=1", last_resp, n_resp - n0);
      end
   endtask

   task automatic test_backpressure();
      int n0, n_acc;
      logic ok;
      cur = 1;
      for (int i = 0; i < 6; i++) issue(1, 1'b1, 4'hF, 12'h100 + 12'(i), 32'hA5000000 + i);
      resp_ready[1] = 0;
      n0 = n_resp;
      n_acc = 0;
      req_valid[1] = 1;
      req_write[1] = 0;
      req_addr[1]  = 12'h100;
      for (int t = 0; t < 10; t++) begin
         @(negedge clk);
         ok = req_ready[1];
         @(posedge clk);
         #1;
         if (ok) begin
            n_acc++;
            if (n_acc == 6) req_valid[1] = 0;
            else req_addr[1] = 12'h100 + 12'(n_acc);
         end
      end
      @(negedge clk);
      checks++;
      if (n_acc !== 4 || req_ready[1] !== 1'b0 || n_resp !== n0) begin
         failures++;
         $display("FAIL credit_stall got acc=%0d rdy=%b resps=%0d want acc=4 rdy=0 resps=0", n_acc, req_ready[1], n_resp - n0);
      end
      @(posedge clk);
      #1;
      req_valid[1]  = 0;
      resp_ready[1] = 1;
      wait_drain();
      checks++;
      if (n_resp !== n0 + 4 || last_resp !== 32'hA5000003) begin
         failures++;
         $display("FAIL credit_drain got resps=%0d last=%h want resps=4 last=a5000003", n_resp - n0, last_resp);
      end
      @(negedge clk);
      checks++;
      if (req_ready[1] !== 1'b1) begin
         failures++;
         $display("FAIL credit_return got=%b want=1", req_ready[1]);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_back_to_back(input int k);
      int n0, c0, c1;
      cur = k;
      resp_ready[k] = 1;
      for (int i = 0; i < 16; i++) issue(k, 1'b1, 4'hF, 12'h200 + 12'(i), 32'hC0DE0000 + i);
      n0 = n_resp;
      c0 = 0;
      for (int i = 0; i < 16; i++) begin
         issue(k, 1'b0, 4'h0, 12'h200 + 12'(i), 32'h0);
         if (i == 0) c0 = acc_cyc;
      end
      c1 = acc_cyc;
      wait_drain();
      checks++;
      if (c1 - c0 !== 15) begin
         failures++;
         $display("FAIL stream_accept inst=%0d got=%0d want=15 cycles", k, c1 - c0);
      end
      checks++;
      if (n_resp - n0 !== 16 || last_pop !== c1 + pl(k) + 2) begin
         failures++;
         $display("FAIL stream_resp inst=%0d got resps=%0d lag=%0d want resps=16 lag=%0d", k, n_resp - n0, last_pop - c1, pl(k) + 2);
      end
   endtask

   task automatic test_random(input int k, input int n);
      int n0, nr;
      bit done;
      bram_req_t r;
      cur = k;
      resp_ready[k] = 1;
      for (int i = 0; i < 16; i++) issue(k, 1'b1, 4'hF, 12'(i), $urandom);
      n0 = n_resp;
      nr = 0;
      done = 0;
      fork
         begin
            for (int i = 0; i < n; i++) begin
               r.write  = ($urandom_range(0, 2) == 0);
               r.byteen = 4'($urandom);
               r.addr   = 12'($urandom_range(0, 15));
               r.data   = $urandom;
               if (!r.write) nr++;
               if ($urandom_range(0, 3) == 0) begin
                  @(posedge clk);
                  #1;
               end
               issue(k, r.write, r.byteen, r.addr, r.data);
            end
            done = 1;
         end
         while (!done) begin
            resp_ready[k] = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
         end
      join
      resp_ready[k] = 1;
      wait_drain();
      checks++;
      if (n_resp - n0 !== nr) begin
         failures++;
         $display("FAIL random_count inst=%0d got=%0d want=%0d", k, n_resp - n0, nr);
      end
   endtask

   task automatic test_reset_midop();
      int n0;
      cur = 2;
      resp_ready[2] = 1;
      for (int i = 0; i < 6; i++) issue(2, 1'b1, 4'hF, 12'h300 + 12'(i), 32'h5EED0000 + i);
      resp_ready[2] = 0;
      for (int i = 0; i < 5; i++) issue(2, 1'b0, 4'h0, 12'h300 + 12'(i), 32'h0);
      checks++;
      if (resp_valid[2] !== 1'b1) begin
         failures++;
         $display("FAIL midop_queued got=%b want=1", resp_valid[2]);
      end
      rst_n = 0;
      req_valid[2]  = 1;
      req_write[2]  = 1;
      req_byteen[2] = 4'hF;
      #1;
      checks++;
      if (resp_valid[2] !== 1'b0 || req_ready[2] !== 1'b0 || bram_en[2] !== 1'b0 || bram_we[2] !== 4'h0) begin
         failures++;
         $display("FAIL midop_reset got v=%b rdy=%b en=%b we=%h want 0", resp_valid[2], req_ready[2], bram_en[2], bram_we[2]);
      end
      repeat (3) @(negedge clk);
      req_valid[2]  = 0;
      req_write[2]  = 0;
      req_byteen[2] = 0;
      @(posedge clk);
      #1 rst_n = 1;
      resp_ready[2] = 1;
      n0 = n_resp;
      repeat (6) @(negedge clk);
      checks++;
      if (n_resp !== n0) begin
         failures++;
         $display("FAIL stale_resp got=%0d want=0", n_resp - n0);
      end
      @(posedge clk);
      #1;
      issue(2, 1'b0, 4'h0, 12'h302, 32'h0);
      wait_drain();
      checks++;
      if (last_resp !== 32'h5EED0002 || n_resp !== n0 + 1) begin
         failures++;
         $display("FAIL post_midop_read got=%h resps=%0d want=5eed0002 resps=1", last_resp, n_resp - n0);
      end
   endtask

   initial begin
      for (int k = 0; k < N; k++) begin
         req_valid[k]  = 0;
         req_write[k]  = 0;
         req_byteen[k] = 0;
         req_addr[k]   = 0;
         req_data[k]   = 0;
         resp_ready[k] = 1;
      end
      test_reset();
      test_basic();
      test_partial();
      test_backpressure();
      test_back_to_back(0);
      test_back_to_back(1);
      test_random(0, 200);
      test_random(1, 1000);
      test_reset_midop();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
